// File: rtl/best_move_selector.sv
// best_move_selector: reduces the move_evaluator output stream for one
// search node to its best move, that move's eval and a legal-move count.
// After the generator reports done, it waits out the evaluator pipeline
// and then pulses valid_out once.
// Optional feature macro: BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
// (beta cutoff, which adds the beta_in, cutoff_out and abort_out ports).
module best_move_selector #(
  parameter int                 PIPE_DEPTH   = 2,
  parameter logic signed [15:0] NO_MOVE_EVAL = -16'sd30000,
  parameter int                 CNT_W        = 8,
  parameter int                 MOVE_W       = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic                done_in,
  input  logic [MOVE_W-1:0]   move_in,
  input  logic signed [15:0]  eval_in,
  input  logic                valid_in,
  output logic [MOVE_W-1:0]   best_move_out,
  output logic signed [15:0]  best_eval_out,
  output logic [CNT_W-1:0]    nb_legal_out,
  output logic                no_legal_out,
  output logic                busy_out,
  output logic                valid_out
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
  ,
  input  logic signed [15:0]  beta_in,
  output logic                cutoff_out,
  output logic                abort_out
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, REPORT} state_t;

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          take, better, hit, cut_q;

`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
  logic signed [15:0] beta_q;
  assign cut_q = cutoff_out;
`else
  assign cut_q = 1'b0;
`endif

  // Move acceptance: COLLECT always; DRAIN only if no cutoff has fired.
  always_comb begin
    take   = valid_in && ((state == COLLECT) || ((state == DRAIN) && !cut_q));
    better = $signed(eval_in) > $signed(best_eval_out);
    hit    = 1'b0;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
    hit    = take && (state == COLLECT) && ($signed(eval_in) >= $signed(beta_q));
`endif
  end

  assign no_legal_out = (nb_legal_out == '0);

  // Node FSM with the running reduction and registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      best_move_out <= '0;
      best_eval_out <= NO_MOVE_EVAL;
      nb_legal_out  <= '0;
      busy_out      <= 1'b0;
      valid_out     <= 1'b0;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
      beta_q        <= '0;
      cutoff_out    <= 1'b0;
      abort_out     <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
      abort_out <= 1'b0;
`endif
      // take is never set in IDLE, so this cannot collide with the start clear
      if (take) begin
        if (better) begin
          best_move_out <= move_in;
          best_eval_out <= eval_in;
        end
        if (nb_legal_out != {CNT_W{1'b1}}) nb_legal_out <= nb_legal_out + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_in) begin
            state         <= COLLECT;
            busy_out      <= 1'b1;
            best_move_out <= '0;
            best_eval_out <= NO_MOVE_EVAL;
            nb_legal_out  <= '0;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
            cutoff_out    <= 1'b0;
            beta_q        <= beta_in;
`endif
          end
        end
        COLLECT: begin
          if (hit || done_in) begin
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
            if (hit) begin
              cutoff_out <= 1'b1;
              abort_out  <= 1'b1;
            end
`endif
            if (PIPE_DEPTH == 0) begin
              state     <= REPORT;
              valid_out <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= REPORT;
            valid_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        REPORT: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_best_move_selector.sv
// Bench for best_move_selector: directed protocol scenarios plus randomized
// nodes checked against a queue-based reference of the accepted moves.
module tb_best_move_selector;
  localparam int PD = 2;
  localparam int CW = 8;
  localparam int MW = 16;
  localparam logic signed [15:0] NME = -16'sd30000;

  logic              clk = 0, rst_n = 1, start = 0, done = 0, vin = 0;
  logic [MW-1:0]     mv = '0;
  logic signed [15:0] ev = '0;
  logic [MW-1:0]     bm;
  logic signed [15:0] be;
  logic [CW-1:0]     nb;
  logic              nol, busy, vo;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
  logic signed [15:0] beta = 16'sh7fff;
  logic              cutoff, abort;
`endif

  best_move_selector #(.PIPE_DEPTH(PD), .NO_MOVE_EVAL(NME), .CNT_W(CW), .MOVE_W(MW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .done_in(done),
    .move_in(mv), .eval_in(ev), .valid_in(vin),
    .best_move_out(bm), .best_eval_out(be), .nb_legal_out(nb),
    .no_legal_out(nol), .busy_out(busy), .valid_out(vo)
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
    , .beta_in(beta), .cutoff_out(cutoff), .abort_out(abort)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int vo_cnt = 0, ab_cnt = 0;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (vo === 1'b1) vo_cnt++;
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
    if (abort === 1'b1) ab_cnt++;
`endif
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  // Reference: every move the protocol says must be accepted, in order.
  logic [MW-1:0]      qm[$];
  logic signed [15:0] qe[$];

  // One clock of stimulus; acc says whether the protocol accepts this move.
  task automatic step(input bit v, input logic [MW-1:0] m, input logic signed [15:0] e,
                      input bit d, input bit s, input bit acc);
    vin = v; mv = m; ev = e; done = d; start = s;
    @(posedge clk); #1;
    if (v && acc) begin qm.push_back(m); qe.push_back(e); end
    vin = 0; done = 0; start = 0;
  endtask

  // Best = earliest move holding the maximum eval, if that maximum beats NME.
  task automatic model(output logic [MW-1:0] xm, output logic signed [15:0] xe, output int xn);
    int mx = -100000;
    xn = (qe.size() > 255) ? 255 : qe.size();
    foreach (qe[i]) if (int'(qe[i]) > mx) mx = int'(qe[i]);
    xm = '0; xe = NME;
    if (mx > int'(NME)) begin
      for (int i = 0; i < qe.size(); i++)
        if (int'(qe[i]) == mx) begin xm = qm[i]; xe = qe[i]; break; end
    end
  endtask

  function automatic logic signed [15:0] reval();
    logic signed [15:0] e = 16'($urandom);
    if (e == 16'sh7fff) e = 0;   // keep clear of the default (max) beta
    return e;
  endfunction

  task automatic begin_node();
    qm.delete(); qe.delete();
    step(0, '0, '0, 0, 1, 0);
  endtask

  // Drain cycles; early flags any valid_out seen before the last one.
  task automatic run_drain(input bit rnd, output bit early);
    early = 0;
    for (int i = 0; i < PD; i++) begin
      if (vo !== 1'b0) early = 1;
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom), reval(), 0, 0, 1);
    end
  endtask

  task automatic test_reset();
    int v0;
    rst_n = 0; #1;
    total++; if (bm !== 0 || be !== NME || nb !== 0) begin bad++; $display("FAIL reset_vals: got %0h/%0d/%0d want 0/-30000/0", bm, be, nb); end
    total++; if (nol !== 1 || busy !== 0 || vo !== 0) begin bad++; $display("FAIL reset_flags: got nol=%b busy=%b vo=%b want 1/0/0", nol, busy, vo); end
    repeat (2) @(posedge clk); #1; rst_n = 1;
    begin_node();
    step(1, 16'h1111, 16'sd500, 0, 0, 1);
    step(1, 16'h2222, 16'sd900, 0, 0, 1);
    v0 = vo_cnt;
    rst_n = 0; #1;
    total++; if (bm !== 0 || be !== NME || nb !== 0 || busy !== 0 || nol !== 1) begin bad++; $display("FAIL reset_mid: got %0h/%0d/%0d busy=%b nol=%b want 0/-30000/0/0/1", bm, be, nb, busy, nol); end
    repeat (3) @(posedge clk); #1; rst_n = 1;
    step(1, 16'h3333, 16'sd5, 1, 0, 0);
    repeat (PD + 3) step(0, '0, '0, 0, 0, 0);
    total++; if (vo_cnt !== v0 || busy !== 0 || nb !== 0) begin bad++; $display("FAIL reset_discard: got pulses=%0d busy=%b nb=%0d want 0/0/0", vo_cnt - v0, busy, nb); end
  endtask

  task automatic test_basic();
    bit early;
    begin_node();
    total++; if (busy !== 1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    step(1, 16'h000A, 16'sd10, 0, 0, 1);
    step(1, 16'h000B, 16'sd250, 0, 0, 1);
    step(1, 16'h000C, -16'sd40, 0, 0, 1);
    step(1, 16'h000D, 16'sd250, 0, 0, 1);
    step(0, '0, '0, 1, 0, 0);
    run_drain(0, early);
    total++; if (early !== 0 || vo !== 1) begin bad++; $display("FAIL basic_latency: got early=%b vo=%b want 0/1", early, vo); end
    total++; if (bm !== 16'h000B || be !== 16'sd250 || nb !== 4 || nol !== 0) begin bad++; $display("FAIL basic_result: got %0h/%0d/%0d/%b want b/250/4/0", bm, be, nb, nol); end
    step(1, 16'h00EE, 16'sd999, 0, 0, 0);   // move during REPORT is ignored
    total++; if (vo !== 0 || busy !== 0 || be !== 16'sd250 || nb !== 4) begin bad++; $display("FAIL basic_after: got vo=%b busy=%b %0d/%0d want 0/0/250/4", vo, busy, be, nb); end
  endtask

  task automatic test_no_legal();
    bit early; int v0 = vo_cnt;
    begin_node();
    step(0, '0, '0, 1, 0, 0);
    run_drain(0, early);
    total++; if (vo !== 1 || be !== NME || nol !== 1 || nb !== 0 || bm !== 0) begin bad++; $display("FAIL no_legal: got vo=%b %0d nol=%b nb=%0d want 1/-30000/1/0", vo, be, nol, nb); end
    repeat (4) step(0, '0, '0, 0, 0, 0);
    total++; if (vo_cnt - v0 !== 1) begin bad++; $display("FAIL no_legal_pulses: got %0d want 1", vo_cnt - v0); end
  endtask

  task automatic test_drain_overlap();
    begin_node();
    step(1, 16'h0005, 16'sd5, 1, 0, 1);
    step(0, '0, '0, 0, 0, 0);
    step(1, 16'h0007, 16'sd7, 0, 0, 1);
    total++; if (vo !== 1 || be !== 16'sd7 || bm !== 16'h0007 || nb !== 2) begin bad++; $display("FAIL drain_overlap: got vo=%b %0d/%0h/%0d want 1/7/7/2", vo, be, bm, nb); end
    step(0, '0, '0, 0, 0, 0);
  endtask

  task automatic test_start_in_drain();
    int v0 = vo_cnt;
    begin_node();
    step(1, 16'h0042, 16'sd42, 0, 0, 1);
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 0, 1, 0);               // start during DRAIN
    step(0, '0, '0, 0, 0, 0);
    total++; if (vo !== 1 || nb !== 1 || be !== 16'sd42) begin bad++; $display("FAIL start_drain_report: got vo=%b nb=%0d be=%0d want 1/1/42", vo, nb, be); end
    repeat (4) step(0, '0, '0, 0, 0, 0);
    total++; if (vo_cnt - v0 !== 1 || busy !== 0) begin bad++; $display("FAIL start_drain_pulses: got %0d busy=%b want 1/0", vo_cnt - v0, busy); end
    total++; if (be !== 16'sd42 || bm !== 16'h0042) begin bad++; $display("FAIL hold_after_report: got %0d/%0h want 42/42", be, bm); end
    begin_node();
    total++; if (busy !== 1 || nb !== 0 || be !== NME || bm !== 0) begin bad++; $display("FAIL restart: got busy=%b nb=%0d be=%0d bm=%0h want 1/0/-30000/0", busy, nb, be, bm); end
    step(0, '0, '0, 1, 0, 0);
    repeat (PD + 1) step(0, '0, '0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit early; logic [MW-1:0] xm; logic signed [15:0] xe; int xn;
    for (int it = 0; it < 20; it++) begin
      begin_node();
      for (int c = 0; c < int'($urandom_range(0, 12)); c++)
        step(1'($urandom_range(0, 1)), 16'($urandom), reval(), 0, 0, 1);
      step(1'($urandom_range(0, 1)), 16'($urandom), reval(), 1, 0, 1);
      run_drain(1, early);
      model(xm, xe, xn);
      total++; if (early !== 0 || vo !== 1) begin bad++; $display("FAIL rand_latency[%0d]: got early=%b vo=%b want 0/1", it, early, vo); end
      total++; if (bm !== xm || be !== xe || nb !== CW'(xn) || nol !== (xn == 0)) begin bad++; $display("FAIL rand_result[%0d]: got %0h/%0d/%0d want %0h/%0d/%0d", it, bm, be, nb, xm, xe, xn); end
      step(1, 16'($urandom), 16'sd32000, 0, 0, 0);
      total++; if (vo !== 0 || busy !== 0 || be !== xe) begin bad++; $display("FAIL rand_report_ignore[%0d]: got vo=%b busy=%b be=%0d want 0/0/%0d", it, vo, busy, be, xe); end
    end
  endtask

  task automatic test_saturation();
    bit early; logic [MW-1:0] xm; logic signed [15:0] xe; int xn;
    begin_node();
    for (int c = 0; c < 300; c++) step(1, 16'($urandom), reval(), 0, 0, 1);
    step(0, '0, '0, 1, 0, 0);
    run_drain(0, early);
    model(xm, xe, xn);
    total++; if (vo !== 1 || nb !== 8'd255 || nol !== 0 || be !== xe || bm !== xm) begin bad++; $display("FAIL saturation: got vo=%b nb=%0d be=%0d want 1/255/%0d", vo, nb, be, xe); end
    step(0, '0, '0, 0, 0, 0);
  endtask

`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
  task automatic test_cutoff();
    int a0 = ab_cnt;
    beta = 16'sd100;
    begin_node();
    beta = 16'sh7fff;                       // must have been latched on start
    step(1, 16'h0014, 16'sd20, 0, 0, 1);
    step(1, 16'h0096, 16'sd150, 0, 0, 1);
    total++; if (abort !== 1 || cutoff !== 1) begin bad++; $display("FAIL cutoff_fire: got abort=%b cutoff=%b want 1/1", abort, cutoff); end
    step(1, 16'h012C, 16'sd300, 0, 0, 0);   // draining move ignored
    total++; if (abort !== 0 || vo !== 0) begin bad++; $display("FAIL cutoff_abort_pulse: got abort=%b vo=%b want 0/0", abort, vo); end
    step(0, '0, '0, 0, 0, 0);
    total++; if (vo !== 1 || be !== 16'sd150 || bm !== 16'h0096 || nb !== 2 || cutoff !== 1) begin bad++; $display("FAIL cutoff_result: got vo=%b %0d/%0h/%0d c=%b want 1/150/96/2/1", vo, be, bm, nb, cutoff); end
    repeat (2) step(0, '0, '0, 0, 0, 0);
    total++; if (ab_cnt - a0 !== 1 || cutoff !== 1) begin bad++; $display("FAIL cutoff_hold: got pulses=%0d c=%b want 1/1", ab_cnt - a0, cutoff); end
    begin_node();
    total++; if (cutoff !== 0) begin bad++; $display("FAIL cutoff_clear: got %b want 0", cutoff); end
    step(0, '0, '0, 1, 0, 0);
    repeat (PD + 1) step(0, '0, '0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_no_legal();
    test_drain_overlap();
    test_start_in_drain();
    test_random();
    test_saturation();
`ifdef BEST_MOVE_SELECTOR_BETA_CUTOFF_EN
    test_cutoff();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
